axis_pkt_fifo: RTL and testbench

//  Parametrised AXI4-Stream FIFO, successor to the plain stream FIFO. Adds tlast

---
 rtl/axis_pkt_fifo_if.sv | 13 +
 rtl/axis_pkt_fifo.sv | 106 ++++++++++
 tb/tb_axis_pkt_fifo.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_pkt_fifo_if.sv
// AXI4-Stream beat channel: data, end-of-packet and the valid/ready handshake.
// The master drives the beat, the slave answers with tready.
interface axis_pkt_fifo_if #(
  parameter int WIDTH = 32
) ();
  logic [WIDTH-1:0] tdata;
  logic             tlast;
  logic             tvalid;
  logic             tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_pkt_fifo.sv
// First-word-fall-through AXI4-Stream FIFO with tlast carriage, optional
// store-and-forward packet gating, occupancy level and almost-full/empty flags.
// DEPTH may be any value >= 2; pointers wrap explicitly at DEPTH-1.
module axis_pkt_fifo #(
  parameter int WIDTH         = 32,
  parameter int DEPTH         = 16,
  parameter int PACKET_MODE   = 0,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 1,
  localparam int LW           = $clog2(DEPTH + 1)
) (
  input  logic            aclk,
  input  logic            areset,
  axis_pkt_fifo_if.slave  s_axis,
  axis_pkt_fifo_if.master m_axis,
  output logic [LW-1:0]   level,
  output logic            almost_full,
  output logic            almost_empty
);

  localparam int PW = $clog2(DEPTH);
  typedef logic [PW-1:0] ptr_t;

  // Each entry holds {tlast, tdata}.
  logic [WIDTH:0]  mem [DEPTH];
  ptr_t            wr_ptr;
  ptr_t            rd_ptr;
  logic [LW-1:0]   pkt_count;
  logic            full_q;

  logic            wr_en;
  logic            rd_en;
  logic            head_last;
  logic            head_valid;
  logic [LW-1:0]   level_next;
  logic [LW-1:0]   pkt_next;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // tready comes from the registered full flag, so a read in the same cycle
  // never opens a slot for a write; it only depends on reset combinationally.
  assign s_axis.tready = !areset && !full_q;
  assign wr_en         = s_axis.tvalid && s_axis.tready;

  // In packet mode the head is only offered once a whole packet is stored,
  // except when full: then the FIFO must drain a packet longer than DEPTH.
  assign head_valid = (level != '0) &&
                      ((PACKET_MODE == 0) || (pkt_count != '0) || full_q);
  assign head_last  = mem[rd_ptr][WIDTH];
  assign rd_en      = head_valid && m_axis.tready;

  assign m_axis.tvalid = head_valid;
  assign m_axis.tdata  = mem[rd_ptr][WIDTH-1:0];
  assign m_axis.tlast  = head_last;

  // Next occupancy and stored-packet count from this cycle's handshakes.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    level_next = level;
    pkt_next   = pkt_count;
    unique case ({wr_en, rd_en})
      2'b10:   level_next = level + LW'(1);
      2'b01:   level_next = level - LW'(1);
      default: level_next = level;
    endcase
    unique case ({wr_en && s_axis.tlast, rd_en && head_last})
      2'b10:   pkt_next = pkt_count + LW'(1);
      2'b01:   pkt_next = pkt_count - LW'(1);
      default: pkt_next = pkt_count;
    endcase
  end

  // Pointers, level, packet count and flags all advance on the same edge.
  always_ff @(posedge aclk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (areset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      pkt_count    <= '0;
      full_q       <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
      level        <= level_next;
      pkt_count    <= pkt_next;
      full_q       <= (level_next == LW'(DEPTH));
      almost_full  <= (level_next >= LW'(AFULL_THRESH));
      almost_empty <= (level_next <= LW'(AEMPTY_THRESH));
    end
  end

  // Beat storage.
  always_ff @(posedge aclk) begin
    // NOTE: the storage array is deliberately not reset; level and pointers
    // alone decide which entries are live, so stale contents are never shown.
    if (wr_en) mem[wr_ptr] <= {s_axis.tlast, s_axis.tdata};
  end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Self-checking bench for axis_pkt_fifo. Three instances (DEPTH=5 stream,
// DEPTH=5 packet mode, DEPTH=7 stream) share one stimulus driver; a queue
// model of stored beats predicts level, flags, handshakes and head beat.
module tb_axis_pkt_fifo;

  localparam int W = 32;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  int          sel = 0;
  logic [W-1:0] drv_tdata = '0;
  logic        drv_tlast = 1'b0;
  logic        drv_svalid = 1'b0;
  logic        drv_mready = 1'b0;

  int checks = 0;
  int failures = 0;
  string cur = "init";

  // model configuration of the selected instance
  int m_depth = 5;
  int m_mode = 0;
  int m_afull = 3;
  int m_aempty = 1;

  logic [W:0] q[$];

  axis_pkt_fifo_if #(.WIDTH(W)) s0 (), m0 (), s1 (), m1 (), s2 (), m2 ();
  logic [2:0] lvl0, lvl1, lvl2;
  logic af0, af1, af2, ae0, ae1, ae2;

  assign s0.tdata = drv_tdata;  assign s0.tlast = drv_tlast;
  assign s1.tdata = drv_tdata;  assign s1.tlast = drv_tlast;
  assign s2.tdata = drv_tdata;  assign s2.tlast = drv_tlast;
  assign s0.tvalid = drv_svalid && (sel == 0);
  assign s1.tvalid = drv_svalid && (sel == 1);
  assign s2.tvalid = drv_svalid && (sel == 2);
  assign m0.tready = drv_mready && (sel == 0);
  assign m1.tready = drv_mready && (sel == 1);
  assign m2.tready = drv_mready && (sel == 2);

  axis_pkt_fifo #(.WIDTH(W), .DEPTH(5), .PACKET_MODE(0)) u_fifo0 (
    .aclk(aclk), .areset(areset), .s_axis(s0.slave), .m_axis(m0.master),
    .level(lvl0), .almost_full(af0), .almost_empty(ae0));
  axis_pkt_fifo #(.WIDTH(W), .DEPTH(5), .PACKET_MODE(1)) u_fifo1 (
    .aclk(aclk), .areset(areset), .s_axis(s1.slave), .m_axis(m1.master),
    .level(lvl1), .almost_full(af1), .almost_empty(ae1));
  axis_pkt_fifo #(.WIDTH(W), .DEPTH(7), .PACKET_MODE(0), .AFULL_THRESH(5),
                  .AEMPTY_THRESH(2)) u_fifo2 (
    .aclk(aclk), .areset(areset), .s_axis(s2.slave), .m_axis(m2.master),
    .level(lvl2), .almost_full(af2), .almost_empty(ae2));

  // observed outputs of the selected instance
  int           obs_level;
  logic [W-1:0] obs_tdata;
  logic         obs_tlast, obs_mvalid, obs_sready, obs_afull, obs_aempty;
  always_comb begin
    obs_level  = int'(lvl0);
    obs_tdata  = m0.tdata;
    obs_tlast  = m0.tlast;
    obs_mvalid = m0.tvalid;
    obs_sready = s0.tready;
    obs_afull  = af0;
    obs_aempty = ae0;
    if (sel == 1) begin
      obs_level = int'(lvl1); obs_tdata = m1.tdata; obs_tlast = m1.tlast;
      obs_mvalid = m1.tvalid; obs_sready = s1.tready; obs_afull = af1; obs_aempty = ae1;
    end else if (sel == 2) begin
      obs_level = int'(lvl2); obs_tdata = m2.tdata; obs_tlast = m2.tlast;
      obs_mvalid = m2.tvalid; obs_sready = s2.tready; obs_afull = af2; obs_aempty = ae2;
    end
  end

  task automatic select_dut(input int s);
    sel = s;
    m_depth  = (s == 2) ? 7 : 5;
    m_mode   = (s == 1) ? 1 : 0;
    m_afull  = (s == 2) ? 5 : 3;
    m_aempty = (s == 2) ? 2 : 1;
  endtask

  function automatic int stored_packets();
    int n = 0;
    foreach (q[i]) if (q[i][W]) n++;
    return n;
  endfunction

  // One clock: drive inputs at the falling edge, compare every output with
  // the model, then apply the predicted handshakes to the model.
  task automatic cycle(input logic [W-1:0] d, input logic l, input logic sv,
                       input logic mr, output logic wrote, output logic rd);
    int sz;
    logic ev, er;
    @(negedge aclk);
    drv_tdata = d; drv_tlast = l; drv_svalid = sv; drv_mready = mr;
    #1;
    sz = q.size();
    er = (sz < m_depth);
    ev = (sz != 0) && ((m_mode == 0) || (stored_packets() != 0) || (sz == m_depth));
    checks++;
    if (obs_level !== sz) begin
      failures++; $display("FAIL %s level: got %0d expected %0d", cur, obs_level, sz);
    end
    checks++;
    if (obs_sready !== er) begin
      failures++; $display("FAIL %s s_tready: got %b expected %b", cur, obs_sready, er);
    end
    checks++;
    if (obs_mvalid !== ev) begin
      failures++; $display("FAIL %s m_tvalid: got %b expected %b", cur, obs_mvalid, ev);
    end
    checks++;
    if (obs_afull !== (sz >= m_afull)) begin
      failures++; $display("FAIL %s almost_full: got %b at level %0d", cur, obs_afull, sz);
    end
    checks++;
    if (obs_aempty !== (sz <= m_aempty)) begin
      failures++; $display("FAIL %s almost_empty: got %b at level %0d", cur, obs_aempty, sz);
    end
    if (ev) begin
      checks++;
      if ({obs_tlast, obs_tdata} !== q[0]) begin
        failures++;
        $display("FAIL %s head beat: got last=%b data=%h expected last=%b data=%h",
                 cur, obs_tlast, obs_tdata, q[0][W], q[0][W-1:0]);
      end
    end
    wrote = sv && er;
    rd    = ev && mr;
    @(posedge aclk);
    if (rd) void'(q.pop_front());
    if (wrote) q.push_back({l, d});
    #1;
    drv_svalid = 1'b0;
    drv_mready = 1'b0;
  endtask

  task automatic test_reset();
    cur = "reset";
    @(negedge aclk);
    areset = 1'b1; drv_svalid = 1'b0; drv_mready = 1'b0;
    @(posedge aclk); #1;
    checks++;
    if (obs_sready !== 1'b0) begin
      failures++; $display("FAIL %s tready_in_reset: got %b expected 0", cur, obs_sready);
    end
    @(negedge aclk);
    areset = 1'b0;
    #1;
    checks++;
    if (obs_sready !== 1'b1) begin
      failures++; $display("FAIL %s tready_after: got %b expected 1", cur, obs_sready);
    end
    checks++;
    if (obs_level !== 0) begin
      failures++; $display("FAIL %s level: got %0d expected 0", cur, obs_level);
    end
    checks++;
    if (obs_mvalid !== 1'b0) begin
      failures++; $display("FAIL %s m_tvalid: got %b expected 0", cur, obs_mvalid);
    end
    checks++;
    if (obs_afull !== 1'b0 || obs_aempty !== 1'b1) begin
      failures++;
      $display("FAIL %s flags: got af=%b ae=%b expected af=0 ae=1", cur, obs_afull, obs_aempty);
    end
    q.delete();
  endtask

  task automatic test_fill_drain();
    logic w, r;
    int acc = 0, nr = 0;
    select_dut(0); test_reset(); cur = "fill_drain";
    for (int i = 1; i <= 7; i++) begin
      cycle(W'(i), 1'b0, 1'b1, 1'b0, w, r);
      if (w) acc++;
    end
    checks++;
    if (acc !== 5) begin
      failures++; $display("FAIL %s accepted: got %0d expected 5", cur, acc);
    end
    for (int i = 0; i < 7; i++) begin
      cycle('0, 1'b0, 1'b0, 1'b1, w, r);
      if (r) nr++;
    end
    checks++;
    if (nr !== 5) begin
      failures++; $display("FAIL %s drained: got %0d expected 5", cur, nr);
    end
  endtask

  task automatic test_back_to_back();
    logic w, r;
    int nr = 0;
    select_dut(0); test_reset(); cur = "back_to_back";
    for (int i = 0; i < 20; i++) begin
      cycle($urandom, 1'b0, 1'b1, 1'b1, w, r);
      if (r) nr++;
    end
    checks++;
    if (nr !== 19) begin
      failures++; $display("FAIL %s reads_in_20: got %0d expected 19", cur, nr);
    end
    cycle('0, 1'b0, 1'b0, 1'b1, w, r);
  endtask

  task automatic test_packet_gate();
    logic w, r;
    int nr = 0;
    select_dut(1); test_reset(); cur = "packet_gate";
    for (int i = 0; i < 3; i++) begin
      cycle(32'hA0 + W'(i), i == 2, 1'b1, 1'b1, w, r);
      if (r) nr++;
      if (i < 2) begin
        cycle('0, 1'b0, 1'b0, 1'b1, w, r); if (r) nr++;
        cycle('0, 1'b0, 1'b0, 1'b1, w, r); if (r) nr++;
      end
    end
    checks++;
    if (nr !== 0) begin
      failures++; $display("FAIL %s early_read: got %0d expected 0", cur, nr);
    end
    for (int i = 0; i < 4; i++) begin
      cycle('0, 1'b0, 1'b0, 1'b1, w, r);
      if (r) nr++;
    end
    checks++;
    if (nr !== 3) begin
      failures++; $display("FAIL %s packet_beats: got %0d expected 3", cur, nr);
    end
  endtask

  task automatic test_long_packet();
    logic w, r;
    int nw = 0, nr = 0, cyc = 0;
    select_dut(1); test_reset(); cur = "long_packet";
    while (nr < 8 && cyc < 200) begin
      cycle(32'h100 + W'(nw), nw == 7, nw < 8, 1'b1, w, r);
      if (w) nw++;
      if (r) nr++;
      cyc++;
    end
    checks++;
    if (nr !== 8) begin
      failures++; $display("FAIL %s delivered: got %0d expected 8 (cycles %0d)", cur, nr, cyc);
    end
    cycle('0, 1'b0, 1'b0, 1'b1, w, r);
    checks++;
    if (obs_mvalid !== 1'b0) begin
      failures++; $display("FAIL %s idle_valid: got %b expected 0", cur, obs_mvalid);
    end
  endtask

  task automatic run_random(input int s, input int beats, input logic pkts);
    logic w, r, ph;
    int nw = 0, nr = 0, cyc = 0;
    select_dut(s); test_reset();
    while (nr < beats && cyc < 20000) begin
      ph = ((cyc / 64) % 2) == 1;
      cycle($urandom,
            pkts && ((nw == beats - 1) || ($urandom_range(0, 3) == 0)),
            (nw < beats) && ($urandom_range(0, 99) < (ph ? 80 : 30)),
            $urandom_range(0, 99) < (ph ? 30 : 80), w, r);
      if (w) nw++;
      if (r) nr++;
      cyc++;
    end
    checks++;
    if (nr !== beats || nw !== beats || q.size() !== 0) begin
      failures++;
      $display("FAIL %s totals: got wr=%0d rd=%0d left=%0d expected %0d/%0d/0",
               cur, nw, nr, q.size(), beats, beats);
    end
  endtask

  task automatic test_reset_mid_packet();
    logic w, r;
    int nr = 0;
    select_dut(1); test_reset(); cur = "reset_mid_packet";
    for (int i = 0; i < 3; i++) cycle(32'hDEAD0 + W'(i), 1'b0, 1'b1, 1'b0, w, r);
    checks++;
    if (obs_level !== 3) begin
      failures++; $display("FAIL %s level_before: got %0d expected 3", cur, obs_level);
    end
    test_reset();
    cur = "reset_mid_packet";
    cycle(32'h11, 1'b0, 1'b1, 1'b0, w, r);
    cycle(32'h22, 1'b1, 1'b1, 1'b0, w, r);
    for (int i = 0; i < 3; i++) begin
      cycle('0, 1'b0, 1'b0, 1'b1, w, r);
      if (r) nr++;
    end
    checks++;
    if (nr !== 2) begin
      failures++; $display("FAIL %s new_packet: got %0d beats expected 2", cur, nr);
    end
  endtask

  initial begin
    select_dut(0);
    repeat (2) @(posedge aclk);
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_packet_gate();
    test_long_packet();
    cur = "random_stream";
    run_random(2, 1000, 1'b0);
    cur = "random_packet";
    run_random(1, 400, 1'b1);
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
